// File: rtl/rom_burst_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rom_ctrl_pkg
// Purpose  : Shared types and constants for the ROM burst arbiter
//            (state enum, default bus widths, requester IDs).
// Revision : 1.0  initial release
// ============================================================================
package rom_ctrl_pkg;

  // Default ROM geometry: 32 words of 8 bits
  localparam int ROM_ADDR_W = 5;
  localparam int ROM_DATA_W = 8;

  // Requester identifiers as they appear on rd_id
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  // Controller states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage : rom_ctrl_pkg
`default_nettype wire

// File: rtl/rom_burst_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_burst_arbiter_if
// Purpose  : Bundles the two requester ports, the ROM port and the read
//            return port. The slave modport is the arbiter's view; the
//            master modport is the requesters/ROM side.
// Revision : 1.0  initial release
// ============================================================================
interface rom_burst_arbiter_if #(
  parameter int ADDR_W = rom_ctrl_pkg::ROM_ADDR_W,
  parameter int DATA_W = rom_ctrl_pkg::ROM_DATA_W
);

  logic              req_a;
  logic              req_b;
  logic [ADDR_W-1:0] start_a;
  logic [ADDR_W-1:0] start_b;
  logic [ADDR_W-1:0] len_a;
  logic [ADDR_W-1:0] len_b;
  logic              gnt_a;
  logic              gnt_b;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_read_en;
  logic [DATA_W-1:0] rom_data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_id;
  logic              rd_last;

  modport slave (
    input  req_a, req_b, start_a, start_b, len_a, len_b, rom_data,
    output gnt_a, gnt_b, rom_addr, rom_read_en,
    output rd_valid, rd_data, rd_id, rd_last
  );

  modport master (
    output req_a, req_b, start_a, start_b, len_a, len_b, rom_data,
    input  gnt_a, gnt_b, rom_addr, rom_read_en,
    input  rd_valid, rd_data, rd_id, rd_last
  );

endinterface : rom_burst_arbiter_if
`default_nettype wire

// File: rtl/rom_burst_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin arbiter. A lone request always wins; on
//            contention the pointer side wins and the pointer then moves to
//            the losing side. Grant is combinational and one-hot.
// Revision : 1.0  initial release
// ============================================================================
module rr_arb2
  import rom_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,   // bit 0 = A, bit 1 = B
  input  logic       upd,   // a grant is being taken this cycle
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  // Winner selection from the current requests and pointer
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (ptr_q == ID_B) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer only moves when both sides competed: it hands priority to the loser
  always_comb begin
    ptr_d = ptr_q;
    if (upd && (req == 2'b11)) begin
      ptr_d = ~ptr_q;
    end
  end

  // Pointer register, A favoured out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= ID_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/rom_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_burst_arbiter
// Purpose  : Shares a single-port ROM between requesters A and B. Grants
//            whole bursts round-robin, walks the ROM address once per cycle
//            and returns registered data tagged with the owner's ID.
// Revision : 1.0  initial release
// ============================================================================
module rom_burst_arbiter
  import rom_ctrl_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  rom_burst_arbiter_if.slave  bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;       // address driven to the ROM
  logic [ADDR_W-1:0] cnt_q, cnt_d;       // words remaining after the current one
  logic              owner_q, owner_d;
  logic              gnt_a_q, gnt_a_d;
  logic              gnt_b_q, gnt_b_d;
  logic              ren_q, ren_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_id_q, rd_id_d;
  logic              rd_last_q, rd_last_d;

  logic [1:0]        arb_gnt;

  // Requests are only arbitrated while idle; in BURST they are ignored
  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({bus.req_b, bus.req_a}),
    .upd   (state_q == IDLE),
    .gnt   (arb_gnt)
  );

  // Next-state, counter and output-register logic
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    gnt_a_d    = 1'b0;
    gnt_b_d    = 1'b0;
    ren_d      = ren_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_id_d    = rd_id_q;
    rd_last_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_gnt[0]) begin
          cur_d   = bus.start_a;
          cnt_d   = bus.len_a;
          owner_d = ID_A;
          gnt_a_d = 1'b1;
          ren_d   = 1'b1;
          state_d = BURST;
        end else if (arb_gnt[1]) begin
          cur_d   = bus.start_b;
          cnt_d   = bus.len_b;
          owner_d = ID_B;
          gnt_b_d = 1'b1;
          ren_d   = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        // Capture the word addressed this cycle; it appears next cycle
        rd_valid_d = 1'b1;
        rd_data_d  = bus.rom_data;
        rd_id_d    = owner_q;
        rd_last_d  = (cnt_q == '0);
        cur_d      = cur_q + ADDR_W'(1);
        if (cnt_q == '0) begin
          ren_d   = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ren_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any burst in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      cnt_q      <= '0;
      owner_q    <= ID_A;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      ren_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_id_q    <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
      ren_q      <= ren_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_id_q    <= rd_id_d;
      rd_last_q  <= rd_last_d;
    end
  end

  assign bus.gnt_a       = gnt_a_q;
  assign bus.gnt_b       = gnt_b_q;
  assign bus.rom_addr    = cur_q;
  assign bus.rom_read_en = ren_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_id       = rd_id_q;
  assign bus.rd_last     = rd_last_q;

endmodule : rom_burst_arbiter
`default_nettype wire

// File: tb/tb_rom_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_burst_arbiter
// Purpose  : Self-checking bench. A schedule-based model predicts every
//            output per cycle from each grant's start/len; directed
//            scenarios add hand-computed literal expectations, then two
//            random requesters run concurrently.
// Revision : 1.0  initial release
// ============================================================================
module tb_rom_burst_arbiter;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;
  localparam int NCYC = 16384;

  logic clk;
  logic rst_n;

  rom_burst_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  rom_burst_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ROM contents: mem[i] = i ^ 8'hA5
  function automatic logic [7:0] rom_word(input int a);
    logic [7:0] v;
    v = 8'(a) ^ 8'hA5;
    return v;
  endfunction

  assign bus.rom_data = rom_word(int'(bus.rom_addr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model: per-cycle expectation schedule -------
  bit         e_gnt_a [NCYC];
  bit         e_gnt_b [NCYC];
  bit         e_ren   [NCYC];
  logic [4:0] e_addr  [NCYC];
  bit         e_valid [NCYC];
  logic [7:0] e_data  [NCYC];
  bit         e_id    [NCYC];
  bit         e_last  [NCYC];

  int         cyc     = 0;
  int         free_at = 0;   // first cycle the arbiter is idle again
  bit         m_ptr   = 1'b0;
  logic [7:0] hold_data = 8'h00;
  int         m_now, m_s, m_l, m_a;
  bit         m_w;

  // On each clock edge, a sampled request while idle books a whole burst
  always @(posedge clk) begin
    m_now = cyc;
    if (rst_n && m_now >= free_at && (bus.req_a || bus.req_b)) begin
      if (bus.req_a && bus.req_b) begin
        m_w   = m_ptr;
        m_ptr = ~m_w;
      end else begin
        m_w = bus.req_b;
      end
      m_s = m_w ? int'(bus.start_b) : int'(bus.start_a);
      m_l = m_w ? int'(bus.len_b)   : int'(bus.len_a);
      if (m_w) e_gnt_b[m_now+1] = 1'b1;
      else     e_gnt_a[m_now+1] = 1'b1;
      for (int k = 0; k <= m_l; k++) begin
        m_a = (m_s + k) % DEPTH;
        e_ren  [m_now+1+k] = 1'b1;
        e_addr [m_now+1+k] = 5'(m_a);
        e_valid[m_now+2+k] = 1'b1;
        e_data [m_now+2+k] = rom_word(m_a);
        e_id   [m_now+2+k] = m_w;
        e_last [m_now+2+k] = (k == m_l);
      end
      free_at = m_now + m_l + 2;
    end
    cyc = m_now + 1;
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_gnt_a",    bus.gnt_a, 0);
      check("rst_gnt_b",    bus.gnt_b, 0);
      check("rst_rom_addr", bus.rom_addr, 0);
      check("rst_rom_ren",  bus.rom_read_en, 0);
      check("rst_rd_valid", bus.rd_valid, 0);
      check("rst_rd_data",  bus.rd_data, 0);
      check("rst_rd_id",    bus.rd_id, 0);
      check("rst_rd_last",  bus.rd_last, 0);
      for (int i = cyc; i < cyc + 64 && i < NCYC; i++) begin
        e_gnt_a[i] = 0; e_gnt_b[i] = 0; e_ren[i] = 0; e_valid[i] = 0; e_last[i] = 0;
      end
      hold_data = 8'h00;
      m_ptr     = 1'b0;
      free_at   = 0;
    end else begin
      check("gnt_a",       bus.gnt_a, e_gnt_a[cyc]);
      check("gnt_b",       bus.gnt_b, e_gnt_b[cyc]);
      check("gnt_excl",    bus.gnt_a & bus.gnt_b, 0);
      check("rom_read_en", bus.rom_read_en, e_ren[cyc]);
      if (e_ren[cyc]) check("rom_addr", bus.rom_addr, e_addr[cyc]);
      check("rd_valid",    bus.rd_valid, e_valid[cyc]);
      check("rd_last",     bus.rd_last, e_last[cyc]);
      if (e_valid[cyc]) begin
        hold_data = e_data[cyc];
        check("rd_id", bus.rd_id, e_id[cyc]);
      end
      check("rd_data",     bus.rd_data, hold_data);
    end
  end

  // ---------------- random requesters --------------------------------------
  task automatic rand_len(output logic [4:0] l);
    if ($urandom_range(0, 5) == 0) l = 5'($urandom_range(0, 31));
    else                           l = 5'($urandom_range(0, 4));
  endtask

  task automatic run_req(input bit side, input int n);
    int waited;
    bit seen;
    logic [4:0] l;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      rand_len(l);
      if (side) begin
        bus.start_b = 5'($urandom_range(0, 31)); bus.len_b = l; bus.req_b = 1'b1;
      end else begin
        bus.start_a = 5'($urandom_range(0, 31)); bus.len_a = l; bus.req_a = 1'b1;
      end
      waited = 0;
      seen   = 1'b0;
      while (!seen && waited < 200) begin
        @(negedge clk);
        waited++;
        seen = side ? bus.gnt_b : bus.gnt_a;
      end
      check(side ? "rand_gnt_b_timeout" : "rand_gnt_a_timeout", 32'(seen), 1);
      if (side) bus.req_b = 1'b0;
      else      bus.req_a = 1'b0;
    end
  endtask

  // ---------------- directed scenarios -------------------------------------
  logic [4:0] w_addr [4];
  logic [7:0] w_data [4];
  logic [1:0] c_gnt  [4];
  int vcount;
  int bseen;

  initial begin
    w_addr = '{5'd30, 5'd31, 5'd0, 5'd1};
    w_data = '{8'hBB, 8'hBA, 8'hA5, 8'hA4};
    c_gnt  = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst_n = 1'b0;
    bus.req_a = 0; bus.req_b = 0;
    bus.start_a = 0; bus.start_b = 0; bus.len_a = 0; bus.len_b = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset then idle
    vcount = 0;
    repeat (4) begin
      @(negedge clk);
      vcount += int'(bus.rom_read_en) + int'(bus.rd_valid) + int'(bus.gnt_a) + int'(bus.gnt_b);
    end
    check("idle_activity", vcount, 0);
    check("idle_rd_data", bus.rd_data, 8'h00);

    // Single burst: A, start 7, len 1
    @(negedge clk); bus.req_a = 1; bus.start_a = 5'd7; bus.len_a = 5'd1;
    @(negedge clk);
    check("single_gnt_a", bus.gnt_a, 1);
    check("single_addr0", bus.rom_addr, 5'd7);
    bus.req_a = 0;
    @(negedge clk);
    check("single_d0", bus.rd_data, 8'hA2);
    check("single_v0", bus.rd_valid, 1);
    check("single_l0", bus.rd_last, 0);
    check("single_id0", bus.rd_id, 0);
    @(negedge clk);
    check("single_d1", bus.rd_data, 8'hAD);
    check("single_l1", bus.rd_last, 1);
    @(negedge clk);
    check("single_done", bus.rd_valid, 0);
    check("single_hold", bus.rd_data, 8'hAD);

    // Wrap: B, start 30, len 3
    bus.req_b = 1; bus.start_b = 5'd30; bus.len_b = 5'd3;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin check("wrap_gnt_b", bus.gnt_b, 1); bus.req_b = 0; end
      if (c <= 4) check("wrap_addr", bus.rom_addr, w_addr[c-1]);
      if (c >= 2) begin
        check("wrap_data", bus.rd_data, w_data[c-2]);
        check("wrap_id", bus.rd_id, 1);
      end
      if (c == 5) check("wrap_last", bus.rd_last, 1);
    end

    // Contention: both high, len 0, grants alternate A,B,A,B
    @(negedge clk);
    bus.req_a = 1; bus.start_a = 5'd2; bus.len_a = 0;
    bus.req_b = 1; bus.start_b = 5'd9; bus.len_b = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c % 2 == 1) check("contend_gnt", {bus.gnt_b, bus.gnt_a}, c_gnt[c/2]);
      if (c == 7) begin bus.req_a = 0; bus.req_b = 0; end
    end

    // Mid-burst request: A 32 words, B raised at cycle 5
    @(negedge clk);
    bus.req_a = 1; bus.start_a = 5'd0; bus.len_a = 5'd31;
    vcount = 0; bseen = 0;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (c == 1) begin check("mid_gnt_a", bus.gnt_a, 1); bus.req_a = 0; end
      if (c == 5) begin bus.req_b = 1; bus.start_b = 5'd3; bus.len_b = 0; end
      if (c <= 33) begin
        bseen += int'(bus.gnt_b);
        vcount += int'(bus.rd_valid);
      end
      if (c == 33) check("mid_last_a", {bus.rd_last, bus.rd_id}, 2'b10);
      if (c == 34) begin check("mid_gnt_b", bus.gnt_b, 1); bus.req_b = 0; end
    end
    check("mid_words", vcount, 32);
    check("mid_no_early_b", bseen, 0);

    // Reset during cycle 4 of a 16-word burst
    repeat (3) @(negedge clk);
    bus.req_a = 1; bus.start_a = 5'd4; bus.len_a = 5'd15;
    @(negedge clk);
    check("rstmid_gnt_a", bus.gnt_a, 1);
    bus.req_a = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("rstmid_ren", bus.rom_read_en, 0);
    check("rstmid_valid", bus.rd_valid, 0);
    check("rstmid_data", bus.rd_data, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    vcount = 0;
    repeat (20) begin
      @(negedge clk);
      vcount += int'(bus.rd_valid) + int'(bus.rom_read_en);
    end
    check("rstmid_quiet", vcount, 0);

    // Random concurrent traffic
    fork
      run_req(1'b0, 40);
      run_req(1'b1, 40);
    join
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global bound on run length
  initial begin
    repeat (12000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exceeded, got %0d cycles, expected under 12000", cyc);
    $fatal(1, "watchdog");
  end

endmodule : tb_rom_burst_arbiter
`default_nettype wire
